if_sample_buffer: RTL and testbench
===================================

Name: if_sample_buffer

Overview:
- Consumes the raw IF sample stream produced by the baseband file reader (`data_out` / `data_valid`) and sits directly downstream of it, in front of the acquisition/tracking correlators.
- Drives the reader's `data_run` request so the reader never outruns buffer space.
- Buffers samples in a first-word-fall-through FIFO and presents them to the correlators over a ready/valid interface.
- Optionally converts offset-binary samples to two's complement and counts any dropped samples.

Parameters:
- WIDTH, 8, sample width in bits; must match the reader's IO_READWIDTH.
- DEPTH, 16, FIFO depth in entries; power of two, at least 4.
- OFFSET_BINARY, 0, when 1 the sample MSB is inverted on output (offset-binary to two's complement).
- OVF_CNT_W, 16, width of the dropped-sample counter.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- enable  input  1  allows new read requests to the reader.
- in_valid  input  1  from reader data_valid.
- in_data  input  WIDTH  from reader data_out.
- run  output  1  to reader data_run.
- out_valid  output  1  FIFO holds at least one sample.
- out_ready  input  1  downstream accepts the sample.
- out_data  output  WIDTH  head sample, after optional format conversion.
- count  output  $clog2(DEPTH)+1  current occupancy.
- overflow  output  1  sticky flag: at least one sample was dropped.
- ovf_count  output  OVF_CNT_W  saturating count of dropped samples.
- clear_ovf  input  1  synchronous clear of overflow and ovf_count.

Behaviour:
- Reset (rst_n low, asynchronous) sets:
  - read and write pointers to 0, count=0;
  - run=0, out_valid=0, overflow=0, ovf_count=0;
  - out_data=0 while the FIFO is empty.
- Storage contents are not reset.
- Reader timing is fixed: data_valid is registered, so a sample answering run in cycle t arrives as in_valid in cycle t+1.
- run is combinational from registered state: run = enable & (count <= DEPTH-2).
  - This guarantees no drop even when out_ready is stuck low, because at most one sample is in flight.
- push = in_valid & (count < DEPTH | pop).
  - in_valid is honoured regardless of enable, so the in-flight sample is still captured after enable falls.
- pop = out_valid & out_ready.
- Simultaneous push and pop:
  - count is unchanged and both pointers advance.
  - This holds when full, which is a legal accept.
  - This holds when empty only if out_valid=0, so no pop occurs; push only.
- Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- count updates every cycle as count + push - pop.
- FWFT output:
  - out_valid = (count != 0).
  - out_data = mem[rd_ptr], with the MSB XORed with OFFSET_BINARY.
  - A sample written in cycle t is visible on out_data in cycle t+1. Minimum latency in_valid to out_valid is 1 cycle.
- Drop: in_valid while count == DEPTH and no pop.
  - The sample is discarded and the FIFO is unchanged.
  - overflow is set to 1 at the next edge.
  - ovf_count increments and saturates at all-ones.
- clear_ovf:
  - Clears overflow and ovf_count at the next edge.
  - If clear_ovf and a drop occur in the same cycle, the result is overflow=1 and ovf_count=1.
- out_data and out_valid must hold stable while out_valid=1 and out_ready=0.
- Reset asserted mid-stream:
  - run drops immediately; the FIFO is emptied and buffered samples are lost.
  - A reader sample arriving after reset deassertion is accepted normally.

Test Plan:
- Reset then enable=1, out_ready=1, reader returns 0,1,2,…,99 -> out_data delivers 0..99 in order, each one cycle after its in_valid; run stays 1; overflow=0.
- enable=1, out_ready=0, DEPTH=16 -> run deasserts once count reaches 15; count settles at 16 with no drop; out_data=first sample, held stable; ovf_count=0.
- From the full state, assert out_ready for one cycle -> count falls to 15, run reasserts, the refill sample arrives the next cycle, count returns to 16, order preserved.
- Force in_valid=1 with data 0xAA while count=16 and out_ready=0 -> sample dropped, overflow=1, ovf_count=1. Three more forced drops -> ovf_count=4. clear_ovf -> both return to 0.
- OFFSET_BINARY=1, inputs 0x00, 0x80, 0xFF -> outputs 0x80, 0x00, 0x7F.
- Fill to 10 entries, assert rst_n=0 asynchronously mid-cycle -> out_valid, run and count go to 0 without a clock edge. After release, the stream restarts from the next reader sample.

Source files
------------

// File: rtl/if_sample_buffer.sv
`default_nettype none
// ============================================================================
// Module  : if_sample_buffer
// Brief   : FWFT sample FIFO between the IF file reader and the correlators,
//           with reader flow control, optional offset-binary conversion and
//           dropped-sample accounting.
// Rev     : 1.0
// ============================================================================
module if_sample_buffer #(
  parameter int WIDTH         = 8,
  parameter int DEPTH         = 16,
  parameter int OFFSET_BINARY = 0,
  parameter int OVF_CNT_W     = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic                   in_valid,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   run,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic [OVF_CNT_W-1:0]   ovf_count,
  input  logic                   clear_ovf
);

  localparam int               c_AW       = $clog2(DEPTH);
  localparam int               c_CW       = c_AW + 1;
  localparam logic [c_CW-1:0]  c_FULL     = c_CW'(DEPTH);
  localparam logic [c_CW-1:0]  c_RUN_MAX  = c_CW'(DEPTH - 2);
  localparam logic [WIDTH-1:0] c_MSB_MASK = (OFFSET_BINARY != 0) ? (WIDTH'(1) << (WIDTH - 1)) : '0;

  logic [WIDTH-1:0]     r_mem [DEPTH];
  logic [c_AW-1:0]      r_wr_ptr;
  logic [c_AW-1:0]      r_rd_ptr;
  logic [c_CW-1:0]      r_count;
  logic                 r_overflow;
  logic [OVF_CNT_W-1:0] r_ovf_count;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == c_FULL);
  assign w_pop   = ~w_empty & out_ready;
  // A full FIFO still accepts a sample when the head leaves in the same cycle.
  assign w_push  = in_valid & (~w_full | w_pop);
  assign w_drop  = in_valid & w_full & ~w_pop;

  // At most one reader sample is in flight, so stopping at DEPTH-1 never drops.
  assign run       = rst_n & enable & (r_count <= c_RUN_MAX);
  assign out_valid = ~w_empty;
  assign out_data  = w_empty ? '0 : (r_mem[r_rd_ptr] ^ c_MSB_MASK);
  assign count     = r_count;
  assign overflow  = r_overflow;
  assign ovf_count = r_ovf_count;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_AW'(1);
      end
      r_count <= r_count + c_CW'(w_push) - c_CW'(w_pop);
    end
  end

  // A drop coinciding with a clear is still recorded as the first drop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow  <= 1'b0;
      r_ovf_count <= '0;
    end else if (clear_ovf) begin
      r_overflow  <= w_drop;
      r_ovf_count <= OVF_CNT_W'(w_drop);
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (~&r_ovf_count) begin
        r_ovf_count <= r_ovf_count + OVF_CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_if_sample_buffer.sv
`default_nettype none
// ============================================================================
// Module  : tb_if_sample_buffer
// Brief   : Self-checking bench for if_sample_buffer against a queue model.
// Rev     : 1.0
// ============================================================================
module tb_if_sample_buffer;

  localparam int W       = 8;
  localparam int D       = 16;
  localparam int OVF_W   = 4;
  localparam int OVF_MAX = (1 << OVF_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic enable = 1'b0;
  logic in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic out_ready = 1'b0;
  logic clear_ovf = 1'b0;

  logic             a_run, a_out_valid, a_overflow;
  logic [W-1:0]     a_out_data;
  logic [4:0]       a_count;
  logic [OVF_W-1:0] a_ovf_count;
  logic             b_run, b_out_valid, b_overflow;
  logic [W-1:0]     b_out_data;
  logic [4:0]       b_count;
  logic [OVF_W-1:0] b_ovf_count;

  always #5 clk = ~clk;

  if_sample_buffer #(.WIDTH(W), .DEPTH(D), .OFFSET_BINARY(0), .OVF_CNT_W(OVF_W)) u_dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .in_valid(in_valid), .in_data(in_data),
    .run(a_run), .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
    .count(a_count), .overflow(a_overflow), .ovf_count(a_ovf_count), .clear_ovf(clear_ovf)
  );

  if_sample_buffer #(.WIDTH(W), .DEPTH(D), .OFFSET_BINARY(1), .OVF_CNT_W(OVF_W)) u_dut_ob (
    .clk(clk), .rst_n(rst_n), .enable(enable), .in_valid(in_valid), .in_data(in_data),
    .run(b_run), .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
    .count(b_count), .overflow(b_overflow), .ovf_count(b_ovf_count), .clear_ovf(clear_ovf)
  );

  // Reference model: sample queue plus drop bookkeeping.
  logic [W-1:0] q[$];
  bit           m_ovf;
  int           m_ovf_cnt;
  bit           reader_mode;
  bit           seq_mode;
  logic [W-1:0] seq_val;
  int           n_pass;
  int           n_chk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_state(input string ph);
    int sz;
    sz = q.size();
    chk({ph, ":run"}, a_run, rst_n && enable && (sz <= D - 2));
    chk({ph, ":out_valid"}, a_out_valid, sz != 0);
    chk({ph, ":out_data"}, a_out_data, (sz != 0) ? q[0] : '0);
    chk({ph, ":count"}, a_count, sz);
    chk({ph, ":overflow"}, a_overflow, m_ovf);
    chk({ph, ":ovf_count"}, a_ovf_count, m_ovf_cnt);
    chk({ph, ":ob_out_data"}, b_out_data, (sz != 0) ? (q[0] ^ 8'h80) : '0);
    chk({ph, ":ob_count"}, b_count, sz);
  endtask

  // One clock: check at the falling edge, advance the model at the rising edge.
  task automatic cycle(input string ph);
    bit e_run, pop, drop;
    int sz;
    @(negedge clk);
    chk_state(ph);
    sz    = q.size();
    e_run = enable && (sz <= D - 2);
    @(posedge clk);
    pop  = (sz != 0) && out_ready;
    drop = in_valid && (sz == D) && !pop;
    if (pop) void'(q.pop_front());
    if (in_valid && !drop) q.push_back(in_data);
    if (clear_ovf) begin
      m_ovf     = drop;
      m_ovf_cnt = drop ? 1 : 0;
    end else if (drop) begin
      m_ovf = 1'b1;
      if (m_ovf_cnt < OVF_MAX) m_ovf_cnt++;
    end
    #1;
    if (reader_mode) begin
      in_valid = e_run;
      in_data  = seq_mode ? seq_val : W'($urandom);
      if (e_run && seq_mode) seq_val++;
    end
  endtask

  initial begin
    n_pass = 0; n_chk = 0; m_ovf = 0; m_ovf_cnt = 0;
    reader_mode = 0; seq_mode = 1; seq_val = '0;

    #1 rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk_state("reset");
    #2 rst_n = 1'b1;

    // In-order streaming of 0..99 with the sink always ready.
    enable = 1'b1; out_ready = 1'b1; reader_mode = 1;
    repeat (110) cycle("stream");

    // Sink stalled: buffer fills to DEPTH with no drop.
    out_ready = 1'b0;
    repeat (25) cycle("stall");
    out_ready = 1'b1; cycle("pop1");
    out_ready = 1'b0;
    repeat (5) cycle("refill");

    // Forced drops, saturation and clears.
    reader_mode = 0; enable = 1'b0; in_valid = 1'b1; in_data = 8'hAA;
    repeat (4) cycle("drop4");
    repeat (16) cycle("drop_sat");
    clear_ovf = 1'b1; cycle("clr_drop");
    in_valid = 1'b0; cycle("clr");
    clear_ovf = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1; cycle("full_push_pop");

    // Offset-binary corner values through the converting instance.
    in_valid = 1'b0;
    repeat (20) cycle("drain");
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 8'h00; cycle("ob");
    in_data = 8'h80; cycle("ob");
    in_data = 8'hFF; cycle("ob");
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) cycle("ob_drain");

    // Randomised reader traffic; no drops are possible here.
    reader_mode = 1; seq_mode = 0;
    for (int i = 0; i < 300; i++) begin
      enable    = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      clear_ovf = ($urandom % 20) == 0;
      cycle("rand_reader");
    end

    // Randomised forced input, drops allowed.
    reader_mode = 0;
    for (int i = 0; i < 300; i++) begin
      enable    = $urandom % 2;
      in_valid  = ($urandom % 4) != 0;
      in_data   = W'($urandom);
      out_ready = ($urandom % 3) == 0;
      clear_ovf = ($urandom % 25) == 0;
      cycle("rand_forced");
    end
    clear_ovf = 1'b0;

    // Asynchronous reset with 10 entries buffered.
    in_valid = 1'b0; enable = 1'b0; out_ready = 1'b1;
    repeat (20) cycle("pre_rst_drain");
    out_ready = 1'b0; in_valid = 1'b1;
    repeat (10) cycle("fill10");
    in_valid = 1'b0; enable = 1'b1;
    #1 rst_n = 1'b0;
    q.delete(); m_ovf = 0; m_ovf_cnt = 0;
    #1 chk_state("async_rst");
    #1 rst_n = 1'b1;
    reader_mode = 1; seq_mode = 1; seq_val = 8'h40; out_ready = 1'b1;
    repeat (30) cycle("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
